// File: rtl/paint_pkg.sv
// Shared types and constants for the paint datapath and the cursor overlay stage.
package paint_pkg;

    // Framebuffer coordinate and pixel types shared with the controller and framebuffer.
    typedef logic [7:0] coord_t;
    typedef logic [7:0] pixel_t;

    // Cursor colour is the saved pixel with these bits flipped.
    localparam pixel_t CURSOR_INV_MASK     = 8'hFF;
    // Blink half-period in clock cycles at the nominal system clock.
    localparam int     CURSOR_BLINK_CYCLES = 12_500_000;

    // Cursor overlay sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESTORE = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAW    = 3'd4,
        ST_DONE    = 3'd5
    } cursor_state_e;

    // Colour drawn over a pixel so the cursor stays visible on any background.
    function automatic pixel_t cursor_colour(input pixel_t pix, input pixel_t mask);
        return pix ^ mask;
    endfunction

endpackage

// File: rtl/cursor_draw_blink_timer.sv
// Free-running blink timer: counts 0..BLINK_CYCLES-1 and toggles phase on every wrap.
module blink_timer
    import paint_pkg::*;
#(
    parameter int BLINK_CYCLES = CURSOR_BLINK_CYCLES
) (
    input  logic clk,
    input  logic rst,
    output logic phase
);

    localparam int             CW   = $clog2(BLINK_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(BLINK_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          phase_q;

    // Count every cycle regardless of the draw sequencer; flip visibility on wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (cnt_q == LAST) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + CW'(1);
            phase_q <= phase_q;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/cursor_draw.sv
// Cursor overlay: restores the pixel under the old cursor, saves the pixel at the
// new position and, while the blink phase is visible, writes its inverse there.
module cursor_draw
    import paint_pkg::*;
#(
    parameter int     BLINK_CYCLES = CURSOR_BLINK_CYCLES,
    parameter pixel_t INV_MASK     = CURSOR_INV_MASK
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  coord_t in_x,
    input  coord_t in_y,
    input  logic   paint,
    input  pixel_t fb_rdata,
    output coord_t fb_x,
    output coord_t fb_y,
    output logic   fb_rd,
    output logic   fb_wr,
    output pixel_t fb_wdata,
    output logic   done,
    output logic   busy
);

    cursor_state_e state_q;
    logic          drawn_q;
    coord_t        old_x_q, old_y_q;
    coord_t        new_x_q, new_y_q;
    pixel_t        saved_q;
    coord_t        fb_x_q, fb_y_q;
    pixel_t        fb_wdata_q;
    logic          fb_rd_q, fb_wr_q;
    logic          done_q, busy_q;
    logic          phase_s;
    logic          drawn_eff_s;

    blink_timer #(
        .BLINK_CYCLES (BLINK_CYCLES)
    ) u_blink (
        .clk   (clk),
        .rst   (rst),
        .phase (phase_s)
    );

    // A paint over the drawn cursor destroys the saved pixel's meaning, so forget it.
    always_comb begin
        drawn_eff_s = drawn_q;
        if (paint && drawn_q && (in_x == old_x_q) && (in_y == old_y_q)) begin
            drawn_eff_s = 1'b0;
        end else begin
            drawn_eff_s = drawn_q;
        end
    end

    // Sequencer; every output is registered and set on the transition into its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            drawn_q    <= 1'b0;
            old_x_q    <= 8'h00;
            old_y_q    <= 8'h00;
            new_x_q    <= 8'h00;
            new_y_q    <= 8'h00;
            saved_q    <= 8'h00;
            fb_x_q     <= 8'h00;
            fb_y_q     <= 8'h00;
            fb_wdata_q <= 8'h00;
            fb_rd_q    <= 1'b0;
            fb_wr_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Strobes are single-cycle; address and data hold between strobes.
            fb_rd_q <= 1'b0;
            fb_wr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    drawn_q <= drawn_eff_s;
                    if (start) begin
                        new_x_q <= in_x;
                        new_y_q <= in_y;
                        busy_q  <= 1'b1;
                        if (drawn_eff_s) begin
                            state_q    <= ST_RESTORE;
                            fb_wr_q    <= 1'b1;
                            fb_x_q     <= old_x_q;
                            fb_y_q     <= old_y_q;
                            fb_wdata_q <= saved_q;
                        end else begin
                            state_q <= ST_READ;
                            fb_rd_q <= 1'b1;
                            fb_x_q  <= in_x;
                            fb_y_q  <= in_y;
                        end
                    end
                end
                ST_RESTORE: begin
                    // The write just issued is visible to the read issued now.
                    drawn_q <= 1'b0;
                    state_q <= ST_READ;
                    fb_rd_q <= 1'b1;
                    fb_x_q  <= new_x_q;
                    fb_y_q  <= new_y_q;
                end
                ST_READ: begin
                    state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    saved_q <= fb_rdata;
                    old_x_q <= new_x_q;
                    old_y_q <= new_y_q;
                    if (phase_s) begin
                        state_q    <= ST_DRAW;
                        fb_wr_q    <= 1'b1;
                        fb_x_q     <= new_x_q;
                        fb_y_q     <= new_y_q;
                        fb_wdata_q <= cursor_colour(fb_rdata, INV_MASK);
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    drawn_q <= 1'b1;
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    // Four-phase handshake: wait for the request to drop.
                    if (!start) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    drawn_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fb_x     = fb_x_q;
    assign fb_y     = fb_y_q;
    assign fb_rd    = fb_rd_q;
    assign fb_wr    = fb_wr_q;
    assign fb_wdata = fb_wdata_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule
